// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: I-cache, D-cache and shared-bus signals around bus_arbiter.
// slave is the arbiter's view of the bundle; master is the surrounding system's.
interface bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic          i_we;
    logic          i_lock;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_wdata;
    logic [DW-1:0] i_rdata;
    logic          i_ready;

    logic          d_req;
    logic          d_we;
    logic          d_lock;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;

    logic          s_req;
    logic          s_we;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic [DW-1:0] s_rdata;
    logic          s_ready;

    logic [1:0]    gnt;

    modport slave (
        input  i_req, i_we, i_lock, i_addr, i_wdata,
        output i_rdata, i_ready,
        input  d_req, d_we, d_lock, d_addr, d_wdata,
        output d_rdata, d_ready,
        output s_req, s_we, s_addr, s_wdata,
        input  s_rdata, s_ready,
        output gnt
    );

    modport master (
        output i_req, i_we, i_lock, i_addr, i_wdata,
        input  i_rdata, i_ready,
        output d_req, d_we, d_lock, d_addr, d_wdata,
        input  d_rdata, d_ready,
        input  s_req, s_we, s_addr, s_wdata,
        output s_rdata, s_ready,
        input  gnt
    );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: I/D cache masters onto one shared bus, with per-grant beat locking.
// Define BUS_ARB_RR_EN for round-robin ties; otherwise D always wins a tie.
module bus_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_LOCK = 8
) (
    input  logic         clk,
    input  logic         rst,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10
    } state_t;

    localparam logic [7:0] LOCK_LIM = 8'(MAX_LOCK - 1);

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    gnt_q;
    logic [7:0]    lock_q;
    logic [7:0]    lock_d;
    logic [7:0]    lock_inc;

    logic          own_req;
    logic          own_we;
    logic          own_lock;
    logic [AW-1:0] own_addr;
    logic [DW-1:0] own_wdata;
    logic          tie_d;
    logic          sel_i;
    logic          sel_d;

`ifdef BUS_ARB_RR_EN
    // ptr_q = 1 when D was granted last, so a tie goes to the other master.
    logic ptr_q;
    logic ptr_d;
    assign tie_d = ~ptr_q;
`else
    assign tie_d = 1'b1;
`endif

    assign sel_i = (state_q == GNT_I);
    assign sel_d = (state_q == GNT_D);

    always_comb begin : owner_mux
        own_req   = 1'b0;
        own_we    = 1'b0;
        own_lock  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        unique case (1'b1)
            sel_i: begin
                own_req   = bus.i_req;
                own_we    = bus.i_we;
                own_lock  = bus.i_lock;
                own_addr  = bus.i_addr;
                own_wdata = bus.i_wdata;
            end
            sel_d: begin
                own_req   = bus.d_req;
                own_we    = bus.d_we;
                own_lock  = bus.d_lock;
                own_addr  = bus.d_addr;
                own_wdata = bus.d_wdata;
            end
            default: ;
        endcase
    end

    assign lock_inc = (lock_q == 8'hFF) ? lock_q : lock_q + 8'd1;

    always_comb begin : next_state
        state_d = state_q;
        lock_d  = lock_q;
`ifdef BUS_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                lock_d = 8'd0;
                if (bus.i_req && bus.d_req) begin
                    state_d = tie_d ? GNT_D : GNT_I;
                end else if (bus.d_req) begin
                    state_d = GNT_D;
                end else if (bus.i_req) begin
                    state_d = GNT_I;
                end
`ifdef BUS_ARB_RR_EN
                if (state_d != IDLE) begin
                    ptr_d = (state_d == GNT_D);
                end
`endif
            end
            GNT_I, GNT_D: begin
                if (!own_req) begin
                    state_d = IDLE;
                    lock_d  = 8'd0;
                end else if (bus.s_ready) begin
                    if (own_lock && (lock_q < LOCK_LIM)) begin
                        lock_d = lock_inc;
                    end else begin
                        state_d = IDLE;
                        lock_d  = 8'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                lock_d  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            lock_q  <= 8'd0;
`ifdef BUS_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= state_d;
            lock_q  <= lock_d;
`ifdef BUS_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.gnt     = gnt_q;

    assign bus.s_req   = own_req;
    assign bus.s_we    = own_we;
    assign bus.s_addr  = own_addr;
    assign bus.s_wdata = own_wdata;

    // Only the owner sees bus responses; s_ready in IDLE is dropped here.
    assign bus.i_ready = sel_i & bus.s_ready;
    assign bus.i_rdata = sel_i ? bus.s_rdata : '0;
    assign bus.d_ready = sel_d & bus.s_ready;
    assign bus.d_rdata = sel_d ? bus.s_rdata : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed tests for bus_arbiter against a cycle-level owner model.
// Builds with or without BUS_ARB_RR_EN; tie expectations follow the macro.
module tb_bus_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ML = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    bus_arbiter #(.AW(AW), .DW(DW), .MAX_LOCK(ML)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: owner 0 = none, 1 = I, 2 = D; beats = beats done in this grant.
    int owner  = 0;
    int beats  = 0;
    bit last_d = 1'b0;
    bit m_rq;
    bit m_lk;

    function automatic int tie_winner(input bit ld);
`ifdef BUS_ARB_RR_EN
        return ld ? 1 : 2;
`else
        return 2;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner  = 0;
            beats  = 0;
            last_d = 1'b0;
        end else if (owner == 0) begin
            if (bus.i_req && bus.d_req) owner = tie_winner(last_d);
            else if (bus.d_req)         owner = 2;
            else if (bus.i_req)         owner = 1;
            if (owner != 0) begin
                last_d = (owner == 2);
                beats  = 0;
            end
        end else begin
            m_rq = (owner == 1) ? bus.i_req  : bus.d_req;
            m_lk = (owner == 1) ? bus.i_lock : bus.d_lock;
            if (!m_rq) begin
                owner = 0;
            end else if (bus.s_ready) begin
                beats++;
                if (!(m_lk && beats < ML)) owner = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt", bus.gnt,
            owner == 1 ? 2'b01 : owner == 2 ? 2'b10 : 2'b00);
        chk("s_req", bus.s_req,
            owner == 1 ? bus.i_req : owner == 2 ? bus.d_req : 1'b0);
        chk("s_we", bus.s_we,
            owner == 1 ? bus.i_we : owner == 2 ? bus.d_we : 1'b0);
        chk("s_addr", bus.s_addr,
            owner == 1 ? bus.i_addr : owner == 2 ? bus.d_addr : '0);
        chk("s_wdata", bus.s_wdata,
            owner == 1 ? bus.i_wdata : owner == 2 ? bus.d_wdata : '0);
        chk("i_ready", bus.i_ready, owner == 1 ? bus.s_ready : 1'b0);
        chk("i_rdata", bus.i_rdata, owner == 1 ? bus.s_rdata : '0);
        chk("d_ready", bus.d_ready, owner == 2 ? bus.s_ready : 1'b0);
        chk("d_rdata", bus.d_rdata, owner == 2 ? bus.s_rdata : '0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        step();
        bus.i_req   = 1'b0;
        bus.i_we    = 1'b0;
        bus.i_lock  = 1'b0;
        bus.d_req   = 1'b0;
        bus.d_we    = 1'b0;
        bus.d_lock  = 1'b0;
        bus.s_ready = 1'b0;
        bus.s_rdata = '0;
        repeat (2) step();
    endtask

    int nb;
    int k;
    logic [1:0] gs [3];

    initial begin
        bus.i_req = 0; bus.i_we = 0; bus.i_lock = 0;
        bus.i_addr = '0; bus.i_wdata = '0;
        bus.d_req = 0; bus.d_we = 0; bus.d_lock = 0;
        bus.d_addr = '0; bus.d_wdata = '0;
        bus.s_rdata = '0; bus.s_ready = 0;

        @(negedge clk);
        chk("rst_gnt", bus.gnt, 2'b00);
        chk("rst_sreq", bus.s_req, 1'b0);
        step();
        rst = 1'b1;

        // single read
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h100;
        @(negedge clk);
        chk("rd_dec_sreq", bus.s_req, 1'b0);
        chk("rd_dec_gnt", bus.gnt, 2'b00);
        step();
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_gnt", bus.gnt, 2'b01);
        chk("rd_sreq", bus.s_req, 1'b1);
        chk("rd_saddr", bus.s_addr, 32'h100);
        chk("rd_iready", bus.i_ready, 1'b1);
        chk("rd_irdata", bus.i_rdata, 32'hDEADBEEF);
        step();
        bus.i_req   = 1'b0;
        bus.s_ready = 1'b0;
        bus.s_rdata = '0;
        @(negedge clk);
        chk("rd_idle", bus.gnt, 2'b00);

        // abort
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h200;
        step();
        @(negedge clk);
        chk("ab_gnt", bus.gnt, 2'b01);
        step();
        bus.i_req = 1'b0;
        @(negedge clk);
        chk("ab_sreq", bus.s_req, 1'b0);
        chk("ab_gnt_hold", bus.gnt, 2'b01);
        chk("ab_iready", bus.i_ready, 1'b0);
        @(negedge clk);
        chk("ab_idle", bus.gnt, 2'b00);

        // write by D with isolation of I
        idle_all();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h300;
        bus.d_wdata = 32'hCAFEF00D;
        step();
        bus.s_rdata = 32'h12345678;
        @(negedge clk);
        chk("wr_gnt", bus.gnt, 2'b10);
        chk("wr_swe", bus.s_we, 1'b1);
        chk("wr_swdata", bus.s_wdata, 32'hCAFEF00D);
        step();
        bus.s_ready = 1'b1;
        @(negedge clk);
        chk("iso_dready", bus.d_ready, 1'b1);
        chk("iso_drdata", bus.d_rdata, 32'h12345678);
        chk("iso_iready", bus.i_ready, 1'b0);
        chk("iso_irdata", bus.i_rdata, 32'h0);

        // locked burst, I pending
        idle_all();
        bus.d_req   = 1'b1;
        bus.d_lock  = 1'b1;
        bus.d_addr  = 32'h400;
        bus.s_ready = 1'b1;
        bus.s_rdata = 32'h55;
        step();
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h500;
        nb = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.gnt != 2'b10) break;
            if (bus.d_ready) nb++;
        end
        chk("lock_beats", nb, 8);
        chk("lock_idle", bus.gnt, 2'b00);
        @(negedge clk);
`ifdef BUS_ARB_RR_EN
        chk("lock_next", bus.gnt, 2'b01);
`else
        chk("lock_next", bus.gnt, 2'b10);
`endif

        // reset mid-beat, then ties from reset
        idle_all();
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h600;
        step();
        bus.s_ready = 1'b1;
        #1;
        chk("mb_pre_gnt", bus.gnt, 2'b10);
        rst = 1'b0;
        #1;
        chk("mb_rst_gnt", bus.gnt, 2'b00);
        chk("mb_rst_dready", bus.d_ready, 1'b0);
        chk("mb_rst_sreq", bus.s_req, 1'b0);
        step();
        rst        = 1'b1;
        bus.i_req  = 1'b1;
        bus.d_req  = 1'b1;
        k = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.gnt != 2'b00) begin
                gs[k] = bus.gnt;
                k++;
                if (k == 3) break;
            end
        end
        chk("tie_count", k, 3);
        chk("tie1", gs[0], 2'b10);
`ifdef BUS_ARB_RR_EN
        chk("tie2", gs[1], 2'b01);
`else
        chk("tie2", gs[1], 2'b10);
`endif
        chk("tie3", gs[2], 2'b10);

        idle_all();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- AW, 32, address width.
- DW, 32, data width.
- MAX_LOCK, 8, maximum consecutive locked beats per grant (range 1..255).
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk, in, 1, single clock, rising edge.
- rst, in, 1, asynchronous reset, active-low.
- i_req / i_we / i_lock, in, 1 each, instruction-cache master: request, write, hold grant for next beat.
- i_addr / i_wdata, in, AW / DW, instruction-cache master address and write data.
- i_rdata / i_ready, out, DW / 1, instruction-cache master read data and beat done.
- d_req / d_we / d_lock / d_addr / d_wdata / d_rdata / d_ready, same as i_* for the data-cache master.
- s_req / s_we, out, 1 each, shared-bus request and write strobe toward the bus controller.
- s_addr / s_wdata, out, AW / DW, shared-bus address and write data.
- s_rdata / s_ready, in, DW / 1, shared-bus read data and beat done.
- gnt, out, 2, one-hot owner: bit0 = I, bit1 = D, 00 = idle.

Function
REQ-003 FSM states: IDLE, GNT_I, GNT_D; gnt is registered and reflects the state.
REQ-004 IDLE: if any of i_req/d_req is high, the next state is GNT_I or GNT_D per arbitration (REQ-010/011); no slave request is issued in the decision cycle, so minimum latency from req to s_req is 1 cycle.
REQ-005 GNT_x: s_req/s_we/s_addr/s_wdata are driven combinationally from master x; x_ready = s_ready; x_rdata = s_rdata.
REQ-006 Non-granted master: ready = 0, rdata = 0; s_* outputs are 0 in IDLE.
REQ-007 Masters hold req/we/addr/wdata stable from req rise until their ready beat.
REQ-008 Beat completes in GNT_x on the cycle s_ready = 1.
- If x_lock = 1 and the lock count is < MAX_LOCK-1, stay in GNT_x and increment the lock count.
- Otherwise go to IDLE and clear the lock count.
REQ-009 In GNT_x, if x_req drops before s_ready, go to IDLE next cycle (abort) and clear the lock count; s_req follows x_req, so it drops the same cycle.
REQ-010 Arbitration, single request: grant the requester.
REQ-011 Arbitration, both requests in IDLE: decided by Configuration (REQ-015/016).
REQ-012 The lock count is 8 bits and saturates; MAX_LOCK = 1 disables lock-hold, so every beat returns to IDLE.
REQ-013 s_ready in IDLE is ignored, and no master ready is asserted.

Reset
REQ-014 When rst is low, asynchronously:
- state = IDLE, gnt = 00, lock count = 0, RR pointer = I.
- All outputs read 0 (s_req, i_ready, d_ready = 0).
- A reset mid-beat abandons the beat; the first decision after release is made in IDLE.

Configuration
REQ-015 With BUS_ARB_RR_EN defined, ties are round-robin.
- A 1-bit pointer records the last master granted.
- On a tie, the other master wins.
- The pointer updates on every IDLE->GNT transition.
- The reset pointer value is I, so D wins the first tie.
REQ-016 With BUS_ARB_RR_EN undefined, there is fixed priority and D always wins ties; no pointer register exists.

Verification
REQ-017 Single read: i_req=1, addr=0x100, s_ready one cycle later with s_rdata=0xDEADBEEF -> gnt=01, s_req high 1 cycle after i_req, i_ready=1 with i_rdata=0xDEADBEEF, then IDLE.
REQ-018 Tie, RR_EN defined: both req from reset -> D, then I, then D; with RR_EN undefined -> D served on every tie.
REQ-019 Lock: d_lock=1 and d_req held for 12 beats with MAX_LOCK=8 -> 8 beats back-to-back with no IDLE cycle, then IDLE; a pending i_req is granted next (RR).
REQ-020 Abort: grant I, drop i_req before s_ready -> s_req=0 the same cycle, IDLE next cycle, no i_ready pulse.
REQ-021 Reset mid-beat: rst low while in GNT_D -> gnt=00 and d_ready=0 immediately (asynchronously); after release with both req high, D is granted (pointer reset).
REQ-022 Isolation: while D owns the bus, toggle s_ready -> i_ready stays 0 and i_rdata stays 0.
